// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared encodings and the alignment fault check for the
//            load/store memory port.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // A request faults on the illegal size code or on a natural-alignment miss.
    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_fault = 1'b0;
            SZ_HALF: is_fault = offset[0];
            SZ_WORD: is_fault = (offset != 2'b00);
            default: is_fault = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Little-endian byte-lane steering. Merges store data into a
//            previously read word and extracts/extends load data from a word.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store merge: only the addressed lane(s) take new data, the rest keep the old word
    always_comb begin
        o_merged = i_rd_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_offset, 3'b000} +: 8]        = i_wdata[7:0];
            SZ_HALF: o_merged[{i_offset[1], 4'b0000} +: 16]   = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

    // Load extract: pick the lane and sign- or zero-extend to a full word
    always_comb begin
        w_byte = i_rd_word[{i_offset, 3'b000} +: 8];
        w_half = i_rd_word[{i_offset[1], 4'b0000} +: 16];
        case (i_size)
            SZ_BYTE: o_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_load = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_load = i_rd_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port
// Purpose  : Load/store initiator between the execute stage and a word RAM.
//            Sub-word stores run as read-modify-write; loads are extended.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t             r_state;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_fault;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rd;

    logic               w_fault;
    logic               w_word_store;
    logic [DATA_W-1:0]  w_merged;
    logic [DATA_W-1:0]  w_load;

    assign w_fault      = is_fault(req_size, req_addr[1:0]);
    assign w_word_store = r_we && (r_size == SZ_WORD);

    lsu_lane_align u_lane_align (
        .i_rd_word  (r_rd),
        .i_wdata    (r_wdata),
        .i_offset   (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    // Sequencer: request capture, state progression and RAM read capture in WAIT only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_fault    <= w_fault;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_state    <= w_fault ? RESP : ISSUE;
                    end
                end
                ISSUE: r_state <= w_word_store ? RESP : WAIT;
                WAIT: begin
                    r_rd    <= mem_rdata;
                    r_state <= r_we ? WRITE : RESP;
                end
                WRITE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output decode; all strobes derive from the state register so reset drops them at once
    always_comb begin
        req_ready  = (r_state == IDLE);
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_rdata = '0;
        case (r_state)
            ISSUE: begin
                mem_en = 1'b1;
                if (w_word_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_wdata;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = w_merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                if (!r_we && !r_fault) begin
                    resp_rdata = w_load;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_port
// Purpose  : Self-checking bench for lsu_mem_port and lsu_lane_align.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] la_rd, la_wd, la_merged, la_load;
    logic [1:0]  la_off, la_size;
    logic        la_uns;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    lsu_lane_align u_la (
        .i_rd_word  (la_rd),
        .i_wdata    (la_wd),
        .i_offset   (la_off),
        .i_size     (la_size),
        .i_unsigned (la_uns),
        .o_merged   (la_merged),
        .o_load     (la_load)
    );

    // Word RAM with one-cycle read latency; read data is junk when not valid
    logic [31:0] ram [0:63];
    logic [31:0] ram_q;
    logic        ram_vld = 1'b0;
    always @(posedge clk) begin
        ram_vld <= mem_en && !mem_we;
        if (mem_en && mem_we)  ram[mem_addr[7:2]] <= mem_wdata;
        if (mem_en && !mem_we) ram_q <= ram[mem_addr[7:2]];
    end
    assign mem_rdata = ram_vld ? ram_q : 32'hA5C3_0F96;

    // Reference memory as individual bytes, updated per completed request
    logic [7:0] mb [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic la_chk(input logic [1:0] off, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_m, input logic [31:0] exp_l);
        la_off = off; la_size = size; la_uns = uns;
        #1;
        chk("lane_merge", la_merged, exp_m);
        chk("lane_load", la_load, exp_l);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic lit_rd_en, input logic [31:0] lit_rd,
                          input logic lit_wd_en, input logic [31:0] lit_wd);
        int          nb, lat_exp, en_exp, we_exp, n_en, n_we, lat;
        logic        flt;
        logic [31:0] exp_rd, exp_word, base;
        nb     = 1 << size;
        flt    = (size == 2'd3) || ((addr % nb) != 0);
        base   = addr & 32'hFFFF_FFFC;
        exp_rd = 32'h0;
        if (flt) begin
            lat_exp = 1; en_exp = 0; we_exp = 0;
        end else if (we) begin
            for (int i = 0; i < nb; i++) mb[addr[7:0] + i] = wdata[8*i +: 8];
            lat_exp = (nb == 4) ? 2 : 4;
            en_exp  = (nb == 4) ? 1 : 2;
            we_exp  = 1;
        end else begin
            for (int i = 0; i < nb; i++) exp_rd = exp_rd | (32'(mb[addr[7:0] + i]) << (8*i));
            if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((32'd1 << (8*nb)) - 32'd1);
            lat_exp = 3; en_exp = 1; we_exp = 0;
        end
        exp_word = {mb[base[7:0] + 3], mb[base[7:0] + 2], mb[base[7:0] + 1], mb[base[7:0]]};

        for (int k = 0; k < 4 && !req_ready; k++) @(negedge clk);
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'd3; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_F00D;

        n_en = 0; n_we = 0; lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready), 32'd0);
            if (mem_en) begin
                n_en++;
                chk("mem_addr", mem_addr, base);
            end
            if (mem_we) begin
                n_we++;
                chk("mem_wdata", mem_wdata, exp_word);
                if (lit_wd_en) chk("mem_wdata_lit", mem_wdata, lit_wd);
            end
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(lat_exp));
        chk("mem_en_cycles", 32'(n_en), 32'(en_exp));
        chk("mem_we_cycles", 32'(n_we), 32'(we_exp));
        chk("resp_fault", 32'(resp_fault), 32'(flt));
        chk("resp_rdata", resp_rdata, exp_rd);
        if (lit_rd_en) chk("resp_rdata_lit", resp_rdata, lit_rd);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("ready_idle", 32'(req_ready), 32'd1);
    endtask

    // Byte store interrupted by reset in cycle k after accept (2 = WAIT, 3 = WRITE)
    task automatic abort_req(input logic [31:0] addr, input logic [31:0] wdata, input int k,
                             input logic [31:0] lit_word);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= k; n++) @(negedge clk);
        chk("abort_pre_we", 32'(mem_we), 32'(k == 3));
        rst = 1'b1;
        #1;
        chk("abort_en", 32'(mem_en), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp", 32'(resp_valid), 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_resp_hold", 32'(resp_valid), 32'd0);
        end
        rst = 1'b0;
        chk("abort_ram", ram[addr[7:2]], lit_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        la_rd = 32'h8899_AABB; la_wd = 32'h1234_5677;
        la_chk(2'd0, 2'd0, 1'b0, 32'h8899_AA77, 32'hFFFF_FFBB);
        la_chk(2'd1, 2'd0, 1'b0, 32'h8899_77BB, 32'hFFFF_FFAA);
        la_chk(2'd2, 2'd0, 1'b1, 32'h8877_AABB, 32'h0000_0099);
        la_chk(2'd3, 2'd0, 1'b0, 32'h7799_AABB, 32'hFFFF_FF88);
        la_chk(2'd0, 2'd1, 1'b1, 32'h8899_5677, 32'h0000_AABB);
        la_chk(2'd2, 2'd1, 1'b0, 32'h5677_AABB, 32'hFFFF_8899);
        la_chk(2'd0, 2'd2, 1'b0, 32'h1234_5677, 32'h8899_AABB);

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899_AABB, 1'b0, 32'h0, 1'b1, 32'h8899_AABB);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFAA, 1'b0, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0000_0088, 1'b0, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF_8899, 1'b0, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1, 32'h0000_AABB, 1'b0, 32'h0);

        abort_req(32'h11, 32'h0000_0055, 2, 32'h8899_AABB);
        abort_req(32'h12, 32'h0000_0066, 3, 32'h8899_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8899_AABB, 1'b0, 32'h0);

        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE_1234, 1'b0, 32'h0, 1'b1, 32'h1234_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_AABB, 1'b0, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00EE, 1'b0, 32'h0, 1'b1, 32'hEE34_AABB);

        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);

        do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_1111, 1'b0, 32'h0, 1'b0, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1, 32'hFFFF_FFBE, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
